mem_stage: RTL and testbench

- Pipeline MEM stage between EX and WB.
- Registers the EX→MEM payload and issues loads/stores on an SRAM-like data bus (req/addr_ok/data_ok).
- Stalls EX until the access completes, aligns and extends load data, and presents each retiring instruction to WB for exactly one cycle.
- WB registers its inputs unconditionally, so any cycle without a retiring instruction must present a bubble: wb_ctrl_o is 0, which means RegWrite is 0.

---
 rtl/cpu_defs.sv | 32 +++
 rtl/mem_align.sv | 49 ++++
 rtl/mem_stage.sv | 113 +++++++++++
 tb/tb_mem_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared encodings for the MEM stage: control bit positions, load/store types,
// bus size codes and MEM state encodings.
package cpu_defs;

   localparam int MEMREAD  = 0;
   localparam int MEMWRITE = 1;
   localparam int LDST_LO  = 2;
   localparam int LDST_HI  = 4;

   localparam int REGWRITE = 0;
   localparam int MEM2REG  = 1;

   typedef enum logic [2:0] {
      LDST_W  = 3'b000,
      LDST_H  = 3'b001,
      LDST_HU = 3'b010,
      LDST_B  = 3'b011,
      LDST_BU = 3'b100
   } ldst_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } mem_state_e;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_align.sv
// Combinational load lane extract/extend and store lane replication.
// Address alignment is assumed; addr_i only picks the lane.
import cpu_defs::*;

module mem_align (
   input  logic [2:0]  ldst_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o,
   output logic [1:0]  size_o
);

   logic [15:0] half;
   logic [7:0]  byte_v;

   always_comb begin
      half    = rdata_i[16*addr_i[1] +: 16];
      byte_v  = rdata_i[8*addr_i +: 8];
      load_o  = rdata_i;
      store_o = wdata_i;
      size_o  = SIZE_W;
      case (ldst_i)
         LDST_H: begin
            load_o  = {{16{half[15]}}, half};
            store_o = {2{wdata_i[15:0]}};
            size_o  = SIZE_H;
         end
         LDST_HU: begin
            load_o  = {16'h0000, half};
            store_o = {2{wdata_i[15:0]}};
            size_o  = SIZE_H;
         end
         LDST_B: begin
            load_o  = {{24{byte_v[7]}}, byte_v};
            store_o = {4{wdata_i[7:0]}};
            size_o  = SIZE_B;
         end
         LDST_BU: begin
            load_o  = {24'h000000, byte_v};
            store_o = {4{wdata_i[7:0]}};
            size_o  = SIZE_B;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: latches the EX payload, runs one req/addr_ok/data_ok bus access,
// stalls EX until it completes and retires each instruction to WB for exactly one cycle.
import cpu_defs::*;

module mem_stage #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          ex_valid_i,
   output logic          mem_allowin_o,
   input  logic [DW-1:0] pc_i,
   input  logic [DW-1:0] inst_i,
   input  logic [4:0]    mem_ctrl_i,
   input  logic [9:0]    wb_ctrl_i,
   input  logic [DW-1:0] ALUOut_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [4:0]    db_dest_i,
   output logic          data_req_o,
   output logic          data_wr_o,
   output logic [1:0]    data_size_o,
   output logic [DW-1:0] data_addr_o,
   output logic [DW-1:0] data_wdata_o,
   input  logic          data_addr_ok_i,
   input  logic [DW-1:0] data_rdata_i,
   input  logic          data_data_ok_i,
   output logic [DW-1:0] pc_o,
   output logic [DW-1:0] inst_o,
   output logic [9:0]    wb_ctrl_o,
   output logic [DW-1:0] rdata_o,
   output logic [DW-1:0] ALUOut_o,
   output logic [4:0]    db_dest_o,
   output logic          wb_valid_o
);

   mem_state_e    state_q;
   logic          valid_q;
   logic [DW-1:0] pc_q, inst_q, alu_q, wdata_q, rdata_q;
   logic [4:0]    mem_ctrl_q, dest_q;
   logic [9:0]    wb_ctrl_q;
   logic [DW-1:0] rdata_d, store_dat;
   logic [1:0]    size_dat;
   logic          in_req, is_mem_op;

   mem_align u_align (
      .ldst_i  (mem_ctrl_q[LDST_HI:LDST_LO]),
      .addr_i  (alu_q[1:0]),
      .rdata_i (data_rdata_i),
      .wdata_i (wdata_q),
      .load_o  (rdata_d),
      .store_o (store_dat),
      .size_o  (size_dat)
   );

   assign is_mem_op     = mem_ctrl_i[MEMREAD] | mem_ctrl_i[MEMWRITE];
   assign mem_allowin_o = !valid_q || (state_q == S_DONE);

   // A finishing instruction and a new one may share an edge: accept wins over drain.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q    <= 1'b0;
         state_q    <= S_IDLE;
         pc_q       <= '0;
         inst_q     <= '0;
         mem_ctrl_q <= '0;
         wb_ctrl_q  <= '0;
         alu_q      <= '0;
         wdata_q    <= '0;
         dest_q     <= '0;
         rdata_q    <= '0;
      end else if (ex_valid_i && mem_allowin_o) begin
         valid_q    <= 1'b1;
         state_q    <= is_mem_op ? S_REQ : S_DONE;
         pc_q       <= pc_i;
         inst_q     <= inst_i;
         mem_ctrl_q <= mem_ctrl_i;
         wb_ctrl_q  <= wb_ctrl_i;
         alu_q      <= ALUOut_i;
         wdata_q    <= wdata_i;
         dest_q     <= db_dest_i;
      end else begin
         case (state_q)
            S_REQ:  if (data_addr_ok_i) state_q <= S_WAIT;
            S_WAIT: if (data_data_ok_i) begin
               state_q <= S_DONE;
               rdata_q <= rdata_d;
            end
            S_DONE: if (!ex_valid_i) begin
               valid_q <= 1'b0;
               state_q <= S_IDLE;
            end
            default: ;
         endcase
      end
   end

   assign in_req       = (state_q == S_REQ);
   assign data_req_o   = in_req;
   assign data_wr_o    = in_req & mem_ctrl_q[MEMWRITE];
   assign data_size_o  = in_req ? size_dat : 2'd0;
   assign data_wdata_o = in_req ? store_dat : '0;
   assign data_addr_o  = alu_q;

   // WB latches every cycle, so a non-retiring cycle must look like a bubble.
   assign wb_valid_o = valid_q && (state_q == S_DONE);
   assign wb_ctrl_o  = wb_valid_o ? wb_ctrl_q : 10'd0;
   assign rdata_o    = mem_ctrl_q[MEMREAD] ? rdata_q : '0;
   assign pc_o       = pc_q;
   assign inst_o     = inst_q;
   assign ALUOut_o   = alu_q;
   assign db_dest_o  = dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scripted bus responder, retirement scoreboard and literal checks.
import cpu_defs::*;

module tb_mem_stage;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        ex_valid_i = 1'b0;
   logic        mem_allowin_o;
   logic [31:0] pc_i = '0, inst_i = '0, ALUOut_i = '0, wdata_i = '0;
   logic [4:0]  mem_ctrl_i = '0, db_dest_i = '0;
   logic [9:0]  wb_ctrl_i = '0;
   logic        data_req_o, data_wr_o;
   logic [1:0]  data_size_o;
   logic [31:0] data_addr_o, data_wdata_o;
   logic        data_addr_ok_i = 1'b0, data_data_ok_i = 1'b0;
   logic [31:0] data_rdata_i = '0;
   logic [31:0] pc_o, inst_o, rdata_o, ALUOut_o;
   logic [9:0]  wb_ctrl_o;
   logic [4:0]  db_dest_o;
   logic        wb_valid_o;

   mem_stage #(.DW(32)) dut (
      .clk(clk), .resetn(resetn), .ex_valid_i(ex_valid_i), .mem_allowin_o(mem_allowin_o),
      .pc_i(pc_i), .inst_i(inst_i), .mem_ctrl_i(mem_ctrl_i), .wb_ctrl_i(wb_ctrl_i),
      .ALUOut_i(ALUOut_i), .wdata_i(wdata_i), .db_dest_i(db_dest_i),
      .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_addr_ok_i(data_addr_ok_i),
      .data_rdata_i(data_rdata_i), .data_data_ok_i(data_data_ok_i),
      .pc_o(pc_o), .inst_o(inst_o), .wb_ctrl_o(wb_ctrl_o), .rdata_o(rdata_o),
      .ALUOut_o(ALUOut_o), .db_dest_o(db_dest_o), .wb_valid_o(wb_valid_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_load(input logic [2:0] t, input logic [1:0] a, input logic [31:0] w);
      logic [31:0] s;
      s = w >> (8 * a);
      case (t)
         3'd1:    return s[15] ? (s | 32'hFFFF0000) : (s & 32'h0000FFFF);
         3'd2:    return s & 32'h0000FFFF;
         3'd3:    return s[7] ? (s | 32'hFFFFFF00) : (s & 32'h000000FF);
         3'd4:    return s & 32'h000000FF;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] m_store(input logic [2:0] t, input logic [31:0] w);
      if (t == 3'd0) return w;
      if (t <= 3'd2) return (w & 32'h0000FFFF) * 32'h00010001;
      return (w & 32'h000000FF) * 32'h01010101;
   endfunction

   function automatic logic [1:0] m_size(input logic [2:0] t);
      if (t == 3'd0) return 2'd2;
      return (t <= 3'd2) ? 2'd1 : 2'd0;
   endfunction

   typedef struct {
      logic [9:0]  ctrl;
      logic [31:0] alu, pc, inst, rdata, wdat;
      logic [4:0]  dest;
      logic        is_mem, wr;
      logic [1:0]  size;
   } exp_t;

   exp_t q[$];

   // ---------------- bus responder ----------------
   logic        resp_en = 1'b1;
   int          aok_wait = 0, dok_wait = 1;
   logic [31:0] resp_rdata = '0;

   initial begin
      int req_cnt, dok_cnt;
      req_cnt = 0;
      dok_cnt = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            req_cnt = 0;
            dok_cnt = 0;
         end
         if (resp_en) begin
            data_addr_ok_i = 1'b0;
            data_data_ok_i = 1'b0;
            if (dok_cnt > 0) begin
               dok_cnt--;
               if (dok_cnt == 0) begin
                  data_data_ok_i = 1'b1;
                  data_rdata_i   = resp_rdata;
               end
            end else if (data_req_o) begin
               if (req_cnt == aok_wait) begin
                  data_addr_ok_i = 1'b1;
                  req_cnt = 0;
                  dok_cnt = dok_wait;
               end else begin
                  req_cnt++;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare against the scoreboard ----------------
   initial begin
      exp_t e;
      logic occupied;
      forever begin
         @(negedge clk);
         occupied = (q.size() != 0);
         chk("allowin", {31'd0, mem_allowin_o}, {31'd0, (!occupied || wb_valid_o)});
         if (wb_valid_o) begin
            if (!occupied) chk("spurious_retire", {31'd0, wb_valid_o}, 32'd0);
            else begin
               e = q.pop_front();
               chk("wb_alu",   ALUOut_o,  e.alu);
               chk("wb_ctrl",  {22'd0, wb_ctrl_o}, {22'd0, e.ctrl});
               chk("wb_rdata", rdata_o,   e.rdata);
               chk("wb_dest",  {27'd0, db_dest_o}, {27'd0, e.dest});
               chk("wb_pc",    pc_o,      e.pc);
               chk("wb_inst",  inst_o,    e.inst);
            end
         end else begin
            chk("bubble_ctrl", {22'd0, wb_ctrl_o}, 32'd0);
         end
         if (data_req_o) begin
            if (q.size() == 0) chk("spurious_req", {31'd0, data_req_o}, 32'd0);
            else begin
               e = q[0];
               chk("req_mem",   {31'd0, data_req_o}, {31'd0, e.is_mem});
               chk("req_addr",  data_addr_o,  e.alu);
               chk("req_wr",    {31'd0, data_wr_o}, {31'd0, e.wr});
               chk("req_size",  {30'd0, data_size_o}, {30'd0, e.size});
               if (e.wr) chk("req_wdata", data_wdata_o, e.wdat);
            end
         end
         if (!resetn) q.delete();
         else if (ex_valid_i && mem_allowin_o) begin
            e.ctrl   = wb_ctrl_i;
            e.alu    = ALUOut_i;
            e.pc     = pc_i;
            e.inst   = inst_i;
            e.dest   = db_dest_i;
            e.is_mem = mem_ctrl_i[MEMREAD] | mem_ctrl_i[MEMWRITE];
            e.wr     = mem_ctrl_i[MEMWRITE];
            e.size   = m_size(mem_ctrl_i[4:2]);
            e.wdat   = m_store(mem_ctrl_i[4:2], wdata_i);
            e.rdata  = mem_ctrl_i[MEMREAD] ? m_load(mem_ctrl_i[4:2], ALUOut_i[1:0], resp_rdata) : 32'd0;
            q.push_back(e);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int seq = 0;

   task automatic drive(input logic [4:0] mc, input logic [9:0] wc, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] dst);
      seq++;
      ex_valid_i = 1'b1;
      mem_ctrl_i = mc;
      wb_ctrl_i  = wc;
      ALUOut_i   = alu;
      wdata_i    = wd;
      db_dest_i  = dst;
      pc_i       = 32'h0000_0400 + 32'(seq) * 4;
      inst_i     = 32'hA000_0000 | 32'(seq);
   endtask

   // Holds ex_valid_i until accepted; returns just after the accepting edge.
   task automatic issue(input logic [4:0] mc, input logic [9:0] wc, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] dst);
      int n;
      @(posedge clk); #1;
      drive(mc, wc, alu, wd, dst);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_allowin_o && n < 60);
      chk("issue_accept", {31'd0, mem_allowin_o}, 32'd1);
      @(posedge clk); #1;
      ex_valid_i = 1'b0;
   endtask

   // Counts cycles after accept until the retire cycle; returns at that cycle's negedge.
   task automatic wait_retire(output int n, output int nreq, output int nallow,
                              output logic [31:0] ra, output logic [31:0] rwd,
                              output logic [1:0] rs, output logic rwr);
      n = 0; nreq = 0; nallow = 0; ra = '0; rwd = '0; rs = '0; rwr = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (!wb_valid_o) begin
            if (data_req_o) begin
               nreq++;
               ra = data_addr_o; rwd = data_wdata_o; rs = data_size_o; rwr = data_wr_o;
            end
            if (mem_allowin_o) nallow++;
         end
      end while (!wb_valid_o && n < 60);
      chk("retire_seen", {31'd0, wb_valid_o}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int n, nreq, nallow;
      logic [31:0] ra, rwd;
      logic [1:0]  rs;
      logic        rwr;
      logic [31:0] vals[3];
      vals = '{32'h11, 32'h22, 32'h33};

      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("rst_bus", {28'd0, data_req_o, data_wr_o, data_size_o}, 32'd0);
      chk("rst_data", data_addr_o | data_wdata_o | rdata_o | ALUOut_o | pc_o | inst_o, 32'd0);
      chk("rst_wb", {21'd0, wb_valid_o, wb_ctrl_o}, 32'd0);
      chk("rst_allowin", {31'd0, mem_allowin_o}, 32'd1);

      // back-to-back ALU ops
      @(posedge clk); #1;
      drive(5'd0, 10'd1, vals[0], 32'd0, 5'd1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (k < 2) drive(5'd0, 10'd1, vals[k+1], 32'd0, 5'(k + 2));
         else ex_valid_i = 1'b0;
         @(negedge clk);
         chk("b2b_valid", {31'd0, wb_valid_o}, 32'd1);
         chk("b2b_alu", ALUOut_o, vals[k]);
         chk("b2b_allowin", {31'd0, mem_allowin_o}, 32'd1);
      end
      @(negedge clk);
      chk("b2b_end", {31'd0, wb_valid_o}, 32'd0);

      // LW with delayed handshake
      resp_rdata = 32'hDEADBEEF; aok_wait = 2; dok_wait = 3;
      issue(5'b00001, 10'h003, 32'h0000_1000, 32'd0, 5'd8);
      wait_retire(n, nreq, nallow, ra, rwd, rs, rwr);
      chk("lw_latency", n, 7);
      chk("lw_req_cycles", nreq, 3);
      chk("lw_req_addr", ra, 32'h0000_1000);
      chk("lw_req_size", {30'd0, rs}, 32'd2);
      chk("lw_stall", nallow, 0);
      chk("lw_rdata", rdata_o, 32'hDEADBEEF);
      @(negedge clk);
      chk("lw_once", {31'd0, wb_valid_o}, 32'd0);

      // lane selection, best-case handshake
      resp_rdata = 32'h8081F0FF; aok_wait = 0; dok_wait = 1;
      issue(5'b01101, 10'h003, 32'h0000_3001, 32'd0, 5'd9);
      wait_retire(n, nreq, nallow, ra, rwd, rs, rwr);
      chk("lb_latency", n, 3);
      chk("lb_rdata", rdata_o, 32'hFFFFFFF0);
      issue(5'b10001, 10'h003, 32'h0000_3003, 32'd0, 5'd10);
      wait_retire(n, nreq, nallow, ra, rwd, rs, rwr);
      chk("lbu_rdata", rdata_o, 32'h00000080);
      issue(5'b00101, 10'h003, 32'h0000_3002, 32'd0, 5'd11);
      wait_retire(n, nreq, nallow, ra, rwd, rs, rwr);
      chk("lh_rdata", rdata_o, 32'hFFFF8081);
      issue(5'b01001, 10'h003, 32'h0000_3000, 32'd0, 5'd12);
      wait_retire(n, nreq, nallow, ra, rwd, rs, rwr);
      chk("lhu_rdata", rdata_o, 32'h0000F0FF);

      // SB
      aok_wait = 1; dok_wait = 2;
      issue(5'b01110, 10'h000, 32'h0000_2003, 32'h123456AB, 5'd0);
      wait_retire(n, nreq, nallow, ra, rwd, rs, rwr);
      chk("sb_wr", {31'd0, rwr}, 32'd1);
      chk("sb_size", {30'd0, rs}, 32'd0);
      chk("sb_wdata", rwd, 32'hABABABAB);
      chk("sb_addr", ra, 32'h0000_2003);
      chk("sb_regwrite", {31'd0, wb_ctrl_o[REGWRITE]}, 32'd0);
      chk("sb_rdata", rdata_o, 32'd0);

      // bubble after a lone ALU op
      issue(5'd0, 10'h3FF, 32'h0000_0055, 32'd0, 5'd3);
      @(negedge clk);
      chk("bub_valid", {31'd0, wb_valid_o}, 32'd1);
      chk("bub_ctrl_on", {22'd0, wb_ctrl_o}, 32'h3FF);
      @(negedge clk);
      chk("bub_valid_off", {31'd0, wb_valid_o}, 32'd0);
      chk("bub_ctrl_off", {22'd0, wb_ctrl_o}, 32'd0);
      chk("bub_allowin", {31'd0, mem_allowin_o}, 32'd1);

      // ALU op held by EX while a load is in flight
      resp_rdata = 32'h13579BDF; aok_wait = 1; dok_wait = 1;
      issue(5'b00001, 10'h003, 32'h0000_2000, 32'd0, 5'd4);
      issue(5'd0, 10'h001, 32'h0000_0077, 32'd0, 5'd5);
      wait_retire(n, nreq, nallow, ra, rwd, rs, rwr);
      chk("stall_alu", ALUOut_o, 32'h0000_0077);
      chk("stall_lat", n, 1);

      // reset while waiting for data_ok, then a stray data_ok
      resp_en = 1'b0;
      issue(5'b00001, 10'h003, 32'h0000_0040, 32'd0, 5'd6);
      data_addr_ok_i = 1'b1;
      @(posedge clk); #1;
      data_addr_ok_i = 1'b0;
      @(negedge clk);
      chk("wait_req", {31'd0, data_req_o}, 32'd0);
      chk("wait_valid", {31'd0, wb_valid_o}, 32'd0);
      @(posedge clk); #1 resetn = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
      @(negedge clk);
      chk("mrst_bus", {28'd0, data_req_o, data_wr_o, data_size_o}, 32'd0);
      chk("mrst_data", data_addr_o | data_wdata_o | rdata_o | ALUOut_o | pc_o | inst_o, 32'd0);
      chk("mrst_wb", {21'd0, wb_valid_o, wb_ctrl_o}, 32'd0);
      chk("mrst_allowin", {31'd0, mem_allowin_o}, 32'd1);
      @(posedge clk); #1;
      data_data_ok_i = 1'b1;
      data_rdata_i   = 32'hBADBAD00;
      @(posedge clk); #1;
      data_data_ok_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stray_dok", {31'd0, wb_valid_o}, 32'd0);
         chk("stray_rdata", rdata_o, 32'd0);
      end
      resp_en = 1'b1;

      repeat (2) @(negedge clk);
      chk("sb_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
